// File: rtl/e203_itcm_ram_ctrl_pkg.sv
// e203_itcm_ram_ctrl_pkg: shared ITCM geometry defaults, response-kind type and sleep-limit helper
package e203_itcm_ram_ctrl_pkg;
  localparam int E203_ITCM_BUS_AW = 32;
  localparam int E203_ITCM_RAM_AW = 13;
  localparam int E203_ITCM_RAM_DW = 64;
  localparam int E203_ITCM_RAM_MW = E203_ITCM_RAM_DW / 8;
  localparam logic [15:0] E203_ITCM_BASE_HI = 16'h8000;
  localparam int E203_ITCM_IDLE_LS = 16;
  typedef struct packed {
    logic rd;
    logic err;
  } rsp_kind_t;
  function automatic logic [15:0] ls_limit(input int idle);
    return idle > 0 ? 16'(idle - 1) : 16'd0;
  endfunction
endpackage

// File: rtl/e203_itcm_ram_ctrl_rspbuf.sv
// e203_itcm_ram_ctrl_rspbuf: in-flight (f) and hold (h) response slots covering SRAM read latency under back-pressure
module e203_itcm_ram_ctrl_rspbuf
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int DW = E203_ITCM_RAM_DW
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  rsp_kind_t     i_kind,
  input  logic          i_rsp_ready,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_valid,
  output logic          o_err,
  output logic [DW-1:0] o_rdata,
  output logic          o_f,
  output logic          o_h
);
  logic          r_f, r_h, r_h_err;
  rsp_kind_t     r_f_kind;
  logic [DW-1:0] r_h_data, w_f_data;
  assign w_f_data = (r_f & r_f_kind.rd & ~r_f_kind.err) ? i_ram_dout : '0;
  assign o_valid  = r_f | r_h;
  assign o_rdata  = r_h ? r_h_data : w_f_data;
  assign o_err    = r_h ? r_h_err : (r_f & r_f_kind.err);
  assign o_f      = r_f;
  assign o_h      = r_h;
  // ram_dout is only valid for one cycle, so a stalled response is snapshotted into the hold slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f      <= 1'b0;
      r_f_kind <= '0;
      r_h      <= 1'b0;
      r_h_err  <= 1'b0;
      r_h_data <= '0;
    end else begin
      r_f      <= i_push;
      r_f_kind <= i_kind;
      if (r_f & ~i_rsp_ready) begin
        r_h      <= 1'b1;
        r_h_err  <= r_f_kind.err;
        r_h_data <= w_f_data;
      end else if (r_h & i_rsp_ready) begin
        r_h      <= 1'b0;
        r_h_err  <= 1'b0;
        r_h_data <= '0;
      end
    end
  end
endmodule

// File: rtl/e203_itcm_ram_ctrl.sv
// e203_itcm_ram_ctrl: ICB-to-single-port-SRAM initiator for the ITCM with response buffering and idle light-sleep
module e203_itcm_ram_ctrl
  import e203_itcm_ram_ctrl_pkg::*;
#(
  parameter int                       BUS_AW  = E203_ITCM_BUS_AW,
  parameter int                       RAM_AW  = E203_ITCM_RAM_AW,
  parameter int                       RAM_DW  = E203_ITCM_RAM_DW,
  parameter int                       RAM_MW  = E203_ITCM_RAM_MW,
  parameter logic [BUS_AW-RAM_AW-4:0] BASE_HI = E203_ITCM_BASE_HI,
  parameter int                       IDLE_LS = E203_ITCM_IDLE_LS
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [BUS_AW-1:0] icb_cmd_addr,
  input  logic [RAM_DW-1:0] icb_cmd_wdata,
  input  logic [RAM_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [RAM_DW-1:0] icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_MW-1:0] ram_wem,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout,
  output logic              ram_ls
);
  localparam logic [15:0] LS_MAX = ls_limit(IDLE_LS);
  localparam bit          LS_EN  = IDLE_LS > 0;
  logic        w_accept, w_in_range, w_wake, w_idle, w_f, w_h, w_unused;
  logic        r_ls;
  logic [15:0] r_cnt;
  rsp_kind_t   w_kind;
  assign w_unused      = ^icb_cmd_addr[2:0];
  assign icb_cmd_ready = ~rst & ~w_h & ~(w_f & ~icb_rsp_ready) & ~r_ls;
  assign w_accept      = icb_cmd_valid & icb_cmd_ready;
  assign w_in_range    = icb_cmd_addr[BUS_AW-1:RAM_AW+3] == BASE_HI;
  assign w_kind        = '{rd: icb_cmd_read, err: ~w_in_range};
  assign ram_cs        = w_accept & w_in_range;
  assign ram_we        = ram_cs & ~icb_cmd_read;
  assign ram_addr      = icb_cmd_addr[RAM_AW+2:3];
  assign ram_wem       = icb_cmd_read ? '0 : icb_cmd_wmask;
  assign ram_din       = icb_cmd_wdata;
  assign ram_ls        = r_ls;
  // a command arriving while asleep only wakes the SRAM; it is accepted on the following cycle
  assign w_wake        = r_ls & icb_cmd_valid;
  assign w_idle        = ~w_accept & ~w_f & ~w_h & ~w_wake;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ls  <= 1'b0;
    end else begin
      r_cnt <= ~w_idle ? '0 : (r_cnt == LS_MAX ? r_cnt : r_cnt + 16'd1);
      r_ls  <= w_wake ? 1'b0 : (r_ls | (LS_EN & w_idle & (r_cnt == LS_MAX)));
    end
  end
  e203_itcm_ram_ctrl_rspbuf #(.DW(RAM_DW)) u_rspbuf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_kind     (w_kind),
    .i_rsp_ready(icb_rsp_ready),
    .i_ram_dout (ram_dout),
    .o_valid    (icb_rsp_valid),
    .o_err      (icb_rsp_err),
    .o_rdata    (icb_rsp_rdata),
    .o_f        (w_f),
    .o_h        (w_h)
  );
endmodule

// File: tb/tb_e203_itcm_ram_ctrl.sv
// tb_e203_itcm_ram_ctrl: directed and random ICB traffic against a word-memory scoreboard with a behavioural SRAM
module tb_e203_itcm_ram_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        icb_cmd_valid = 1'b0, icb_cmd_read = 1'b0, icb_rsp_ready = 1'b1;
  logic [31:0] icb_cmd_addr = '0;
  logic [63:0] icb_cmd_wdata = '0;
  logic [7:0]  icb_cmd_wmask = '0;
  logic        icb_cmd_ready, icb_rsp_valid, icb_rsp_err;
  logic [63:0] icb_rsp_rdata;
  logic        ram_cs, ram_we, ram_ls;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din, ram_dout;
  logic [63:0] sram [0:8191];
  logic [63:0] ref_mem [0:8191];
  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;
  exp_t q[$];
  int   checks = 0, errors = 0, n_rsp = 0;
  logic acc = 1'b0;

  always #5 clk = ~clk;

  e203_itcm_ram_ctrl dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls)
  );

  // SRAM: one-cycle read latency; dout is garbage whenever no read was issued
  always @(posedge clk) begin
    if (ram_cs && ram_we)
      for (int b = 0; b < 8; b++) if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= (ram_cs && !ram_we) ? sram[ram_addr] : {$urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    exp_t        e;
    logic        inr;
    logic [12:0] w;
    @(negedge clk);
    acc = icb_cmd_valid && icb_cmd_ready;
    if (!rst) begin
      chk("rsp_valid", icb_rsp_valid, q.size() > 0);
      if (icb_rsp_valid && icb_rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_err", icb_rsp_err, e.err);
        chk("rsp_rdata", icb_rsp_rdata, e.data);
        n_rsp++;
      end
      if (acc) begin
        inr = icb_cmd_addr[31:16] == 16'h8000;
        w   = icb_cmd_addr[15:3];
        chk("ram_cs", ram_cs, inr);
        if (inr) begin
          chk("ram_addr", ram_addr, w);
          chk("ram_we", ram_we, !icb_cmd_read);
          chk("ram_wem", ram_wem, icb_cmd_read ? 8'h00 : icb_cmd_wmask);
          if (!icb_cmd_read)
            for (int b = 0; b < 8; b++) if (icb_cmd_wmask[b]) ref_mem[w][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
        end
        e.err  = !inr;
        e.data = (inr && icb_cmd_read) ? ref_mem[w] : 64'h0;
        q.push_back(e);
      end else chk("ram_cs_idle", ram_cs, 1'b0);
    end
  endtask

  task automatic issue(input logic rd, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = d;
    icb_cmd_wmask = m;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      sample();
      adv();
    end
    chk("issue_acc", acc, 1'b1);
    icb_cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    int          n0;
    logic [63:0] hold_want;
    logic [15:0] tag;
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    icb_cmd_valid = 1'b1;
    adv();
    adv();
    @(negedge clk);
    chk("rst_cmd_ready", icb_cmd_ready, 1'b0);
    chk("rst_rsp_valid", icb_rsp_valid, 1'b0);
    chk("rst_rsp_err", icb_rsp_err, 1'b0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 64'h0);
    chk("rst_ram_cs", ram_cs, 1'b0);
    chk("rst_ram_ls", ram_ls, 1'b0);
    adv();
    icb_cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) issue(1'b0, 32'h8000_0000 + 32'(i * 8), {$urandom, $urandom}, 8'hFF);
    idle(1);
    // full-word write then read back
    issue(1'b0, 32'h8000_0010, 64'h1122334455667788, 8'hFF);
    issue(1'b1, 32'h8000_0010, 64'h0, 8'h00);
    sample();
    chk("rd_full", icb_rsp_rdata, 64'h1122334455667788);
    chk("rd_full_err", icb_rsp_err, 1'b0);
    adv();
    // byte write then read back
    issue(1'b0, 32'h8000_0013, 64'h0000_0000_0000_00AA, 8'h01);
    issue(1'b1, 32'h8000_0010, 64'h0, 8'h00);
    sample();
    chk("rd_byte", icb_rsp_rdata, 64'h11223344556677AA);
    adv();
    // random traffic with random back-pressure and occasional out-of-range tags
    for (int i = 0; i < 120; i++) begin
      tag           = ($urandom_range(0, 7) == 0) ? 16'h9000 : 16'h8000;
      icb_cmd_valid = $urandom_range(0, 2) != 0;
      icb_cmd_read  = $urandom_range(0, 1) == 1;
      icb_cmd_addr  = {tag, 13'($urandom_range(0, 15)), 3'($urandom)};
      icb_cmd_wdata = {$urandom, $urandom};
      icb_cmd_wmask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      icb_rsp_ready = $urandom_range(0, 3) != 0;
      sample();
      adv();
    end
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b1;
    idle(3);
    // back-to-back reads at full throughput
    n0 = n_rsp;
    for (int i = 0; i < 8; i++) begin
      icb_cmd_valid = 1'b1;
      icb_cmd_read  = 1'b1;
      icb_cmd_addr  = 32'h8000_0000 + 32'(i * 8);
      sample();
      chk("b2b_ready", icb_cmd_ready, 1'b1);
      adv();
    end
    icb_cmd_valid = 1'b0;
    idle(1);
    chk("b2b_count", 64'(n_rsp - n0), 64'd8);
    // read word 3 under four cycles of back-pressure
    icb_rsp_ready = 1'b0;
    hold_want = ref_mem[3];
    issue(1'b1, 32'h8000_0018, 64'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("hold_valid", icb_rsp_valid, 1'b1);
      chk("hold_rdata", icb_rsp_rdata, hold_want);
      chk("hold_ready", icb_cmd_ready, 1'b0);
      adv();
    end
    icb_rsp_ready = 1'b1;
    sample();
    chk("hold_hs_ready", icb_cmd_ready, 1'b0);
    adv();
    sample();
    chk("hold_reopen", icb_cmd_ready, 1'b1);
    adv();
    // out-of-range read
    issue(1'b1, 32'h9000_0000, 64'h0, 8'h00);
    sample();
    chk("oor_err", icb_rsp_err, 1'b1);
    chk("oor_rdata", icb_rsp_rdata, 64'h0);
    adv();
    // idle into light sleep, then wake with a read
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("awake", ram_ls, 1'b0);
      adv();
    end
    sample();
    chk("asleep", ram_ls, 1'b1);
    adv();
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 32'h8000_0010;
    sample();
    chk("wake_ready", icb_cmd_ready, 1'b0);
    adv();
    sample();
    chk("wake_ls", ram_ls, 1'b0);
    chk("wake_accept", icb_cmd_ready, 1'b1);
    chk("wake_cs", ram_cs, 1'b1);
    adv();
    icb_cmd_valid = 1'b0;
    idle(1);
    // reset while a response sits in the hold slot
    icb_rsp_ready = 1'b0;
    issue(1'b1, 32'h8000_0008, 64'h0, 8'h00);
    idle(1);
    sample();
    chk("pre_rst_valid", icb_rsp_valid, 1'b1);
    adv();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", icb_cmd_ready, 1'b0);
    adv();
    rst = 1'b0;
    q.delete();
    icb_rsp_ready = 1'b1;
    sample();
    chk("rst_drop_valid", icb_rsp_valid, 1'b0);
    chk("rst_drop_rdata", icb_rsp_rdata, 64'h0);
    adv();
    issue(1'b1, 32'h8000_0018, 64'h0, 8'h00);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e203_itcm_ram_ctrl.md
Name: e203_itcm_ram_ctrl

Overview:
- Initiator side of the ITCM SRAM port: converts a valid/ready ICB-style command/response bus into the single-port SRAM cs/we/wem/addr/din/dout protocol.
- Read data arrives one cycle after cs; the block buffers it against response back-pressure.
- Also drives the SRAM light-sleep (ls) pin after a programmable idle period.
- Sits between the ITCM bus arbiter and e203_itcm_ram.

Parameters:
- BUS_AW, 32, command byte-address width.
- RAM_AW, 13, SRAM word-address width (8192 words).
- RAM_DW, 64, SRAM data width.
- RAM_MW, 8, SRAM byte-write-mask width (RAM_DW/8).
- BASE_HI, 16'h8000, required value of addr[BUS_AW-1:RAM_AW+3] (ITCM region tag).
- IDLE_LS, 16, idle cycles before ram_ls asserts (0 disables sleep).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command accepted when valid&ready.
- icb_cmd_read  in  1  1=read, 0=write.
- icb_cmd_addr  in  BUS_AW  byte address; bits [2:0] ignored.
- icb_cmd_wdata  in  RAM_DW  write data.
- icb_cmd_wmask  in  RAM_MW  byte enables for writes.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response consumed when valid&ready.
- icb_rsp_rdata  out  RAM_DW  read data (0 for writes and errors).
- icb_rsp_err  out  1  address outside ITCM region.
- ram_cs  out  1  SRAM chip select.
- ram_we  out  1  SRAM write enable.
- ram_addr  out  RAM_AW  word address = icb_cmd_addr[RAM_AW+2:3].
- ram_wem  out  RAM_MW  byte mask (icb_cmd_wmask on writes, 0 on reads).
- ram_din  out  RAM_DW  = icb_cmd_wdata.
- ram_dout  in  RAM_DW  SRAM read data, valid the cycle after a read cs.
- ram_ls  out  1  SRAM light sleep.

Behaviour:
- Reset: icb_cmd_ready=0, icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, ram_cs=0, ram_ls=0; flight flag f=0, hold flag h=0, idle counter=0.
- SRAM signals are combinational from the accepted command: ram_cs = valid & ready & in-range; ram_we = ram_cs & ~read.
- Out-of-range command (tag != BASE_HI): accepted without ram_cs; produces a response next cycle with err=1, rdata=0.
- f is set the cycle after any accept and holds the data-vs-write type and err.
- Response is valid when f or h is set. rdata = h ? hold_data : (read & ~err ? ram_dout : 0).
- If f is set and icb_rsp_ready=0: capture the response into hold (h=1) that cycle. h clears on the rsp handshake.
- icb_cmd_ready = ~rst & ~h & ~(f & ~icb_rsp_ready) & ~ram_ls.
  - f and h are never both set.
  - Throughput is 1 command/cycle while icb_rsp_ready=1.
- Latency: command accepted in cycle N; response valid in cycle N+1, combinationally from ram_dout.
- Sleep:
  - The idle counter increments when no accept occurs and f=h=0; otherwise it clears.
  - At count==IDLE_LS-1 (IDLE_LS>0), ram_ls rises next cycle.
  - icb_cmd_valid while ram_ls=1 clears ram_ls next cycle; the command is accepted one cycle later (1-cycle wake penalty).
  - The counter saturates.
- Writes with wmask=0 still assert ram_cs and ram_we with wem=0 and return a response.
- rst mid-transaction drops f, h and any held data. No response is produced for an in-flight command.

Decomposition:
- Shared e203 defines file: E203_ITCM_RAM_AW/DW/MW and the ITCM base tag, used as parameter defaults.
- One natural sub-module, e203_itcm_ram_ctrl_rspbuf: the f/h two-slot response buffer with the hold register.
- Address decode, sleep counter and SRAM drive stay in the top module.

Test Plan:
- Write 0x1122334455667788 at addr 0x80000010 with wmask 0xFF, then read it: ram_addr=2, read rsp rdata=0x1122334455667788 in cycle N+1, err=0.
- Byte write wmask 0x01 data 0xAA to the same word, then read -> 0x11223344556677AA; ram_wem=0x01 on the write cycle.
- Back-to-back reads of words 0..7 with rsp_ready=1 -> 8 responses on 8 consecutive cycles, cmd_ready never low.
- Read word 3, hold rsp_ready=0 for 4 cycles:
  - rsp_valid stays 1 with stable data while ram_dout is perturbed by the bench model.
  - cmd_ready=0 throughout.
  - Handshake then reopens cmd_ready next cycle.
- Read addr 0x90000000 -> no ram_cs, rsp err=1, rdata=0.
- Idle 16 cycles -> ram_ls=1 on cycle 17; then a read is issued -> ram_ls=0 next cycle, cs one cycle later, correct data. Assert rst while a response is held -> rsp_valid=0 next cycle.
